// File: rtl/cordic_vectoring_if.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_if
//   Operand/result bundle for the folded vectoring-mode CORDIC engine.
//
//   Handshake rule (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both high. The valid side holds its payload
//   stable until that edge; ready may change freely and never depends
//   combinationally on valid of the same channel.
//
//   Signals:
//     x_in, y_in   signed Q2.19 operand pair            (source -> engine)
//     in_valid     operand pair present                 (source -> engine)
//     in_ready     engine idle and able to capture      (engine -> source)
//     angle_out    signed Q3.19 atan2(y, x), (-pi, pi]  (engine -> consumer)
//     mag_out      signed Q5.19 magnitude, >= 0         (engine -> consumer)
//     out_valid    result present, held until taken     (engine -> consumer)
//     out_ready    consumer takes the result            (consumer -> engine)
//
//   Modports: slave = engine side, master = source/consumer side.
// -----------------------------------------------------------------------------
interface cordic_vectoring_if #(
    parameter int WORD_LENGTH = 21
) ();
    logic signed [WORD_LENGTH-1:0] x_in;
    logic signed [WORD_LENGTH-1:0] y_in;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [WORD_LENGTH:0]   angle_out;
    logic signed [WORD_LENGTH+2:0] mag_out;
    logic                          out_valid;
    logic                          out_ready;

    modport slave (
        input  x_in,
        input  y_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output angle_out,
        output mag_out,
        output out_valid
    );

    modport master (
        output x_in,
        output y_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  angle_out,
        input  mag_out,
        input  out_valid
    );
endinterface

// File: rtl/cordic_vectoring.sv
// -----------------------------------------------------------------------------
// cordic_vectoring
//   Folded CORDIC engine in vectoring mode: one add/shift stage reused for
//   N_ITERATIONS cycles drives y toward zero, leaving atan2(y, x) in z and
//   K*|v| in x.
//
//   Optional feature macro: CORDIC_VEC_GAIN_COMP_EN
//     defined   -> extra COMP cycle multiplies x by 1/K (318375, Q0.19)
//     undefined -> mag_out carries the CORDIC gain K ~= 1.64676
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     bus          cordic_vectoring_if.slave (operands, results, handshakes)
//     o_dbg_state  current FSM state encoding
//     o_dbg_iter   current micro-rotation index
// -----------------------------------------------------------------------------
module cordic_vectoring #(
    parameter int WORD_LENGTH  = 21,
    parameter int N_ITERATIONS = 17
) (
    input  logic                                clk,
    input  logic                                rst,
    cordic_vectoring_if.slave                   bus,
    output logic [1:0]                          o_dbg_state,
    output logic [$clog2(N_ITERATIONS+1)-1:0]   o_dbg_iter
);
    localparam int XW = WORD_LENGTH + 3;    // x/y datapath with guard bits
    localparam int ZW = WORD_LENGTH + 1;    // angle accumulator
    localparam int IW = $clog2(N_ITERATIONS + 1);
    localparam logic signed [ZW-1:0] HALF_PI = ZW'(823550);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
`ifdef CORDIC_VEC_GAIN_COMP_EN
        S_COMP = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    // round(atan(2^-i) * 2^19)
    function automatic int atan_lut(input int idx);
        case (idx)
            0:       return 411775;
            1:       return 243085;
            2:       return 128439;
            3:       return 65198;
            4:       return 32725;
            5:       return 16379;
            6:       return 8191;
            7:       return 4096;
            8:       return 2048;
            9:       return 1024;
            10:      return 512;
            11:      return 256;
            12:      return 128;
            13:      return 64;
            14:      return 32;
            15:      return 16;
            16:      return 8;
            17:      return 4;
            18:      return 2;
            19:      return 1;
            default: return 0;
        endcase
    endfunction

    state_t                 r_state;
    state_t                 w_next_state;
    logic signed [XW-1:0]   r_x;
    logic signed [XW-1:0]   r_y;
    logic signed [ZW-1:0]   r_z;
    logic [IW-1:0]          r_iter;
    logic                   r_zero;
    logic signed [ZW-1:0]   r_angle;
    logic signed [XW-1:0]   r_mag;

    logic signed [XW-1:0]   w_x_ext;
    logic signed [XW-1:0]   w_y_ext;
    logic signed [XW-1:0]   w_x0;
    logic signed [XW-1:0]   w_y0;
    logic signed [ZW-1:0]   w_z0;
    logic signed [XW-1:0]   w_x_sh;
    logic signed [XW-1:0]   w_y_sh;
    logic signed [ZW-1:0]   w_alpha;
    logic signed [XW-1:0]   w_x_nx;
    logic signed [XW-1:0]   w_y_nx;
    logic signed [ZW-1:0]   w_z_nx;
    logic                   w_last;
    logic                   w_in_ready;
    logic                   w_out_valid;

    // Pre-rotation folds left-half-plane operands into the right half plane
    // by +/-90 degrees so the micro-rotations only need to cover +/-99.9 deg.
    always_comb begin
        w_x_ext = {{3{bus.x_in[WORD_LENGTH-1]}}, bus.x_in};
        w_y_ext = {{3{bus.y_in[WORD_LENGTH-1]}}, bus.y_in};
        w_x0    = w_x_ext;
        w_y0    = w_y_ext;
        w_z0    = '0;
        if (w_x_ext[XW-1]) begin
            if (!w_y_ext[XW-1]) begin
                w_x0 = w_y_ext;
                w_y0 = -w_x_ext;
                w_z0 = HALF_PI;
            end else begin
                w_x0 = -w_y_ext;
                w_y0 = w_x_ext;
                w_z0 = -HALF_PI;
            end
        end
    end

    // Shared micro-rotation stage; all right-hand sides use pre-update values.
    always_comb begin
        w_x_sh  = r_x >>> r_iter;
        w_y_sh  = r_y >>> r_iter;
        w_alpha = ZW'(atan_lut(int'(r_iter)));
        if (!r_y[XW-1]) begin
            w_x_nx = r_x + w_y_sh;
            w_y_nx = r_y - w_x_sh;
            w_z_nx = r_z + w_alpha;
        end else begin
            w_x_nx = r_x - w_y_sh;
            w_y_nx = r_y + w_x_sh;
            w_z_nx = r_z - w_alpha;
        end
    end

    // Index N is a write-back slot: rotations ran at 0..N-1, so this cycle
    // only moves the settled accumulators toward the output registers.
    assign w_last = (r_iter == IW'(N_ITERATIONS));

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam logic [18:0] INV_K = 19'd318375;
    logic signed [XW+18:0]  w_x_wide;
    logic signed [XW+18:0]  w_prod;
    logic signed [XW-1:0]   w_mag_comp;

    // x * 1/K as a constant shift-add, then truncated back to Q.19.
    always_comb begin
        w_x_wide = {{19{r_x[XW-1]}}, r_x};
        w_prod   = '0;
        for (int k = 0; k < 19; k++) begin
            if (INV_K[k]) begin
                w_prod = w_prod + (w_x_wide <<< k);
            end
        end
        w_mag_comp = XW'(w_prod >>> 19);
    end
`endif

    // FSM next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = S_ITER;
                end
            end
            S_ITER: begin
                if (w_last) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    w_next_state = S_COMP;
`else
                    w_next_state = S_DONE;
`endif
                end
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            S_COMP: begin
                w_next_state = S_DONE;
            end
`endif
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath and output registers. The all-zero operand is flagged at
    // capture because the y>=0 branch would otherwise sum the whole LUT into z.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_zero  <= 1'b0;
            r_angle <= '0;
            r_mag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x    <= w_x0;
                        r_y    <= w_y0;
                        r_z    <= w_z0;
                        r_iter <= '0;
                        r_zero <= (bus.x_in == '0) && (bus.y_in == '0);
                    end
                end
                S_ITER: begin
                    if (!w_last) begin
                        r_x    <= w_x_nx;
                        r_y    <= w_y_nx;
                        r_z    <= w_z_nx;
                        r_iter <= r_iter + IW'(1);
                    end
`ifndef CORDIC_VEC_GAIN_COMP_EN
                    else begin
                        r_angle <= r_zero ? '0 : r_z;
                        r_mag   <= r_zero ? '0 : r_x;
                    end
`endif
                end
`ifdef CORDIC_VEC_GAIN_COMP_EN
                S_COMP: begin
                    r_angle <= r_zero ? '0 : r_z;
                    r_mag   <= r_zero ? '0 : w_mag_comp;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.angle_out = r_angle;
    assign bus.mag_out   = r_mag;
    assign o_dbg_state   = r_state;
    assign o_dbg_iter    = r_iter;

endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;
    localparam int WL = 21;
    localparam int NI = 17;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int LAT    = NI + 2;
    localparam int MAG_1  = 524288;    // |1.0|
    localparam int MAG_R2 = 741455;    // sqrt(2)
    localparam int MAG_2  = 1048576;   // |2.0|
    localparam int MAG_H  = 370728;    // sqrt(2)/2
`else
    localparam int LAT    = NI + 1;
    localparam int MAG_1  = 863377;    // K * 1.0
    localparam int MAG_R2 = 1220999;   // K * sqrt(2)
    localparam int MAG_2  = 1726754;   // K * 2.0
    localparam int MAG_H  = 610499;    // K * sqrt(2)/2
`endif
    localparam int TOL = 16;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic [4:0] dbg_iter;
    int         n_checks;
    int         n_errors;

    cordic_vectoring_if #(.WORD_LENGTH(WL)) bus ();

    cordic_vectoring #(
        .WORD_LENGTH  (WL),
        .N_ITERATIONS (NI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_iter  (dbg_iter)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        n_checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Wait for out_valid after a capture edge; returns cycles counted.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input int xv, input int yv,
                          input int exp_ang, input int exp_mag, input int tol);
        int cyc;
        @(negedge clk);
        bus.x_in     = WL'(xv);
        bus.y_in     = WL'(yv);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_val({tag, "_busy"}, bus.in_ready, 0, 0);
        wait_result(cyc);
        check_val({tag, "_lat"}, cyc, LAT, 0);
        check_val({tag, "_ang"}, bus.angle_out, exp_ang, tol);
        check_val({tag, "_mag"}, bus.mag_out, exp_mag, tol);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_rdy"}, bus.in_ready, 1, 0);
        check_val({tag, "_ovld"}, bus.out_valid, 0, 0);
    endtask

    initial begin
        int cyc;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", bus.in_ready, 1, 0);
        check_val("rst_out_valid", bus.out_valid, 0, 0);
        check_val("rst_angle", bus.angle_out, 0, 0);
        check_val("rst_mag", bus.mag_out, 0, 0);
        check_val("rst_state", dbg_state, 0, 0);
        check_val("rst_iter", dbg_iter, 0, 0);
        rst = 1'b1;

        // directed vectors
        run_op("x1_y0",   524288,   0,       0,        MAG_1,  TOL);
        run_op("x0_y1",   0,        524288,  823550,   MAG_1,  TOL);
        run_op("xm1_ym1", -524288,  -524288, -1235324, MAG_R2, TOL);
        run_op("xm2_y0",  -1048576, 0,       1647099,  MAG_2,  TOL);
        check_val("xm2_sign", (bus.angle_out > 0) ? 1 : 0, 1, 0);
        run_op("zero",    0,        0,       0,        0,      0);

        // backpressure with a competing operand pair
        @(negedge clk);
        bus.x_in     = WL'(262144);
        bus.y_in     = WL'(262144);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(cyc);
        check_val("bp_lat", cyc, LAT, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.x_in     = WL'(-524288);
            bus.y_in     = WL'(100000);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_val("bp_ovld", bus.out_valid, 1, 0);
            check_val("bp_in_ready", bus.in_ready, 0, 0);
            check_val("bp_state", dbg_state, 3, 0);
            check_val("bp_ang", bus.angle_out, 411775, TOL);
            check_val("bp_mag", bus.mag_out, MAG_H, TOL);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val("bp_rel_rdy", bus.in_ready, 1, 0);
        check_val("bp_rel_ovld", bus.out_valid, 0, 0);
        check_val("bp_hold_ang", bus.angle_out, 411775, TOL);
        check_val("bp_hold_mag", bus.mag_out, MAG_H, TOL);
        @(posedge clk);
        #1;
        check_val("bp_ignored", dbg_state, 0, 0);

        // reset in the middle of the iterations
        @(negedge clk);
        bus.x_in     = WL'(0);
        bus.y_in     = WL'(524288);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_val("mid_iter", dbg_iter, 8, 0);
        rst = 1'b0;
        #1;
        check_val("mid_rst_ovld", bus.out_valid, 0, 0);
        check_val("mid_rst_rdy", bus.in_ready, 1, 0);
        check_val("mid_rst_state", dbg_state, 0, 0);
        check_val("mid_rst_iter", dbg_iter, 0, 0);
        check_val("mid_rst_ang", bus.angle_out, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        run_op("post_rst", 524288, 524288, 411775, MAG_R2, TOL);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
